// File: rtl/div_unit_pkg.sv
// Shared definitions for the execute-stage divider: FSM encoding, decode codes
// and the default operand width.
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        FREE    = 2'b00,
        DIVZERO = 2'b01,
        ON      = 2'b10,
        END     = 2'b11
    } div_state_t;

    // ALU control codes that EX decode uses to select a divide.
    localparam logic [4:0] ALU_DIV  = 5'b11010;
    localparam logic [4:0] ALU_DIVU = 5'b11011;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, dvd} left, trial-subtract the
// divisor, and shift the resulting quotient bit into the low end.
module div_step
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [2*WIDTH-1:0] rem_dvd,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH-1:0] rem_dvd_next,
    output logic               q_bit
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    always_comb begin
        // Trial value is one bit wider because the shifted remainder can reach 2*divisor-1.
        trial        = rem_dvd[2*WIDTH-1:WIDTH-1];
        diff         = trial - {1'b0, divisor};
        q_bit        = ~diff[WIDTH];
        rem_dvd_next = {(q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0]),
                        rem_dvd[WIDTH-2:0], q_bit};
    end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 DIV/DIVU unit; holds the pipeline via stall_o and returns
// {remainder, quotient} for the HI/LO write path.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opa_i,
    input  logic [WIDTH-1:0]   opb_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stall_o,
    output logic [1:0]         dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    div_state_t         state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] rem_dvd;
    logic [2*WIDTH-1:0] rem_dvd_next;
    logic [WIDTH-1:0]   divisor;
    logic               neg_q;
    logic               neg_r;
    logic               q_bit;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   fix_q;
    logic [WIDTH-1:0]   fix_r;

    assign stall_o   = start_i & ~ready_o & ~annul_i;
    assign dbg_state = state;

    always_comb begin
        abs_a = (signed_i && opa_i[WIDTH-1]) ? -opa_i : opa_i;
        abs_b = (signed_i && opb_i[WIDTH-1]) ? -opb_i : opb_i;
        fix_q = neg_q ? -rem_dvd[WIDTH-1:0] : rem_dvd[WIDTH-1:0];
        fix_r = neg_r ? -rem_dvd[2*WIDTH-1:WIDTH] : rem_dvd[2*WIDTH-1:WIDTH];
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_dvd      (rem_dvd),
        .divisor      (divisor),
        .rem_dvd_next (rem_dvd_next),
        .q_bit        (q_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= FREE;
            cnt      <= '0;
            ready_o  <= 1'b0;
            result_o <= '0;
            rem_dvd  <= '0;
            divisor  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    if (start_i && !annul_i) begin
                        if (opb_i == '0) begin
                            state <= DIVZERO;
                        end else begin
                            state   <= ON;
                            cnt     <= '0;
                            rem_dvd <= {{WIDTH{1'b0}}, abs_a};
                            divisor <= abs_b;
                            neg_r   <= signed_i & opa_i[WIDTH-1];
                            neg_q   <= signed_i & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
                        end
                    end
                end
                DIVZERO: begin
                    if (annul_i) begin
                        state <= FREE;
                    end else begin
                        state    <= END;
                        result_o <= '0;
                        ready_o  <= 1'b1;
                    end
                end
                ON: begin
                    if (annul_i) begin
                        state <= FREE;
                    end else if (cnt != CNT_LAST) begin
                        rem_dvd <= rem_dvd_next;
                        cnt     <= cnt + 1'b1;
                    end else begin
                        // Fix-up cycle: restore signs, then publish the result.
                        result_o <= {fix_r, fix_q};
                        ready_o  <= 1'b1;
                        state    <= END;
                    end
                end
                END: begin
                    if (annul_i || !start_i) begin
                        state   <= FREE;
                        ready_o <= 1'b0;
                    end
                end
                default: state <= FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed and random checks of div_unit against an arithmetic reference.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opa_i;
    logic [31:0] opb_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_o;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;

    div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .signed_i  (signed_i),
        .opa_i     (opa_i),
        .opb_i     (opb_i),
        .annul_i   (annul_i),
        .result_o  (result_o),
        .ready_o   (ready_o),
        .stall_o   (stall_o),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: truncating division as the ISA defines it; divide by zero yields zero.
    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        logic [63:0] qv, rv;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end
        q  = x / y;
        r  = x % y;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    task automatic cycle_start();
        @(posedge clk);
        #1;
    endtask

    // Issues a divide at cycle 0 and follows it to ready_o; start stays high.
    task automatic do_div(input bit sgn, input logic [31:0] a, input logic [31:0] b, input string tag);
        int cyc;
        int lat;
        bit stall_ok;
        logic [63:0] exp;
        exp      = model(sgn, a, b);
        lat      = (b == 32'd0) ? 2 : 34;
        cycle_start();
        signed_i = sgn;
        opa_i    = a;
        opb_i    = b;
        annul_i  = 1'b0;
        start_i  = 1'b1;
        cyc      = 0;
        stall_ok = 1'b1;
        @(negedge clk);
        while (!ready_o && cyc < 200) begin
            if (!stall_o) stall_ok = 1'b0;
            cycle_start();
            // Operands after the load edge must be ignored.
            opa_i    = $urandom;
            opb_i    = $urandom;
            signed_i = $urandom_range(0, 1);
            cyc++;
            @(negedge clk);
        end
        check({tag, " latency"}, 64'(cyc), 64'(lat));
        check({tag, " stall_held"}, 64'(stall_ok), 64'd1);
        check({tag, " stall_at_ready"}, 64'(stall_o), 64'd0);
        check({tag, " result"}, result_o, exp);
    endtask

    // Holds start one more cycle, then drops it and checks the return to FREE.
    task automatic release_start(input string tag, input logic [63:0] exp);
        cycle_start();
        @(negedge clk);
        check({tag, " held_ready"}, 64'(ready_o), 64'd1);
        check({tag, " held_result"}, result_o, exp);
        cycle_start();
        start_i = 1'b0;
        @(negedge clk);
        check({tag, " ready_before_drop_edge"}, 64'(ready_o), 64'd1);
        cycle_start();
        @(negedge clk);
        check({tag, " ready_dropped"}, 64'(ready_o), 64'd0);
        check({tag, " state_free"}, 64'(dbg_state), 64'd0);
    endtask

    initial begin
        bit seen_ready;
        logic [31:0] ra, rb;
        bit rs;
        rst      = 1'b0;
        start_i  = 1'b0;
        signed_i = 1'b0;
        opa_i    = '0;
        opb_i    = '0;
        annul_i  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset ready", 64'(ready_o), 64'd0);
        check("reset result", result_o, 64'd0);
        check("reset state", 64'(dbg_state), 64'd0);
        check("reset stall", 64'(stall_o), 64'd0);
        rst = 1'b1;

        do_div(1'b0, 32'd100, 32'd7, "divu_100_7");
        check("divu_100_7 literal", result_o, {32'h00000002, 32'h0000000E});
        release_start("divu_100_7", {32'h00000002, 32'h0000000E});

        do_div(1'b1, 32'hFFFFFFF9, 32'h00000002, "div_m7_2");
        check("div_m7_2 literal", result_o, {32'hFFFFFFFF, 32'hFFFFFFFD});
        release_start("div_m7_2", {32'hFFFFFFFF, 32'hFFFFFFFD});

        do_div(1'b1, 32'h00000007, 32'hFFFFFFFE, "div_7_m2");
        check("div_7_m2 literal", result_o, {32'h00000001, 32'hFFFFFFFD});
        release_start("div_7_m2", {32'h00000001, 32'hFFFFFFFD});

        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
        check("div_ovf literal", result_o, {32'h00000000, 32'h80000000});
        release_start("div_ovf", {32'h00000000, 32'h80000000});

        do_div(1'b0, 32'h80000000, 32'hFFFFFFFF, "divu_big");
        check("divu_big literal", result_o, {32'h80000000, 32'h00000000});
        release_start("divu_big", {32'h80000000, 32'h00000000});

        do_div(1'b1, 32'h12345678, 32'd0, "div_zero");
        release_start("div_zero", 64'd0);

        // Annul mid-divide at cycle 10; no result may appear.
        cycle_start();
        signed_i   = 1'b0;
        opa_i      = 32'd100;
        opb_i      = 32'd7;
        start_i    = 1'b1;
        seen_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ready_o) seen_ready = 1'b1;
            cycle_start();
        end
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        check("annul stall", 64'(stall_o), 64'd0);
        cycle_start();
        annul_i = 1'b0;
        @(negedge clk);
        check("annul state_free", 64'(dbg_state), 64'd0);
        if (ready_o) seen_ready = 1'b1;
        check("annul no_ready", 64'(seen_ready), 64'd0);
        do_div(1'b0, 32'd9, 32'd3, "after_annul");
        check("after_annul literal", result_o, {32'd0, 32'd3});
        release_start("after_annul", {32'd0, 32'd3});

        // Annul while the result is being held.
        do_div(1'b0, 32'd50, 32'd5, "end_annul");
        cycle_start();
        annul_i = 1'b1;
        @(negedge clk);
        check("end_annul stall", 64'(stall_o), 64'd0);
        cycle_start();
        annul_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        check("end_annul ready", 64'(ready_o), 64'd0);
        check("end_annul state", 64'(dbg_state), 64'd0);

        // Start together with annul in FREE must not launch.
        cycle_start();
        start_i = 1'b1;
        annul_i = 1'b1;
        opa_i   = 32'd10;
        opb_i   = 32'd2;
        @(negedge clk);
        check("start_annul stall", 64'(stall_o), 64'd0);
        cycle_start();
        start_i = 1'b0;
        annul_i = 1'b0;
        @(negedge clk);
        check("start_annul state", 64'(dbg_state), 64'd0);

        // Reset at cycle 20 of a divide.
        cycle_start();
        signed_i = 1'b1;
        opa_i    = 32'hFFFF0000;
        opb_i    = 32'd3;
        start_i  = 1'b1;
        repeat (20) cycle_start();
        rst     = 1'b0;
        start_i = 1'b0;
        cycle_start();
        rst = 1'b1;
        @(negedge clk);
        check("midreset ready", 64'(ready_o), 64'd0);
        check("midreset result", result_o, 64'd0);
        check("midreset state", 64'(dbg_state), 64'd0);
        do_div(1'b1, 32'hFFFF0000, 32'd3, "after_reset");
        release_start("after_reset", model(1'b1, 32'hFFFF0000, 32'd3));

        // Random operands, biased toward small divisors and sign corners.
        for (int i = 0; i < 16; i++) begin
            rs = $urandom_range(0, 1);
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom_range(1, 15);
                1: rb = 32'hFFFFFFFF - $urandom_range(0, 15);
                2: rb = (i == 5) ? 32'd0 : $urandom;
                default: rb = $urandom;
            endcase
            do_div(rs, ra, rb, $sformatf("rand%0d", i));
            cycle_start();
            start_i = 1'b0;
            cycle_start();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 (one quotient bit per cycle) 32-bit divider in the execute stage. It serves DIV and DIVU.
- Execute-stage decode asserts start when the ALU control selects a divide. The block holds the pipeline through stall_o, which feeds the hazard unit's stallE/stall generation.
- The 64-bit result {remainder, quotient} goes down the hilowrite path to the HI/LO register (HI = remainder, LO = quotient).

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset (rst=0 at a clk edge resets)
- start_i  input  1  divide requested by the instruction in EX; held high until ready_o is seen
- signed_i  input  1  1 = DIV (two's complement), 0 = DIVU
- opa_i  input  WIDTH  dividend (rs)
- opb_i  input  WIDTH  divisor (rt)
- annul_i  input  1  cancel in-flight divide (flushE / exception)
- result_o  output  2*WIDTH  {remainder, quotient}; valid only while ready_o=1
- ready_o  output  1  result valid (registered)
- stall_o  output  1  pipeline hold request (combinational)

Behaviour:
- Reset (rst=0 at clk edge): state=FREE, cnt=0, ready_o=0, result_o=0. Internal dividend/divisor/sign registers are cleared.
- States: FREE, DIVZERO, ON, END.
- FREE:
  - start_i=1, annul_i=0, opb_i==0 -> DIVZERO.
  - start_i=1, annul_i=0, opb_i!=0 -> ON. Latch |opa|, |opb| (abs only if signed_i), the dividend sign and the quotient sign (sa^sb). cnt=0, partial remainder=0.
  - Otherwise stay in FREE.
- DIVZERO: next edge -> END with result {0,0}. annul_i=1 -> FREE.
- ON:
  - annul_i=1 -> FREE at next edge; nothing is written.
  - Else while cnt<WIDTH: shift {rem, dvd} left 1 bit and trial-subtract the divisor. If rem>=divisor, rem -= divisor and the quotient bit is 1; cnt++.
  - When cnt==WIDTH, one fix-up cycle: negate the quotient if the quotient sign is set; negate the remainder if the dividend sign is set. Load result_o, set ready_o=1, -> END.
- END: ready_o=1 and result_o held stable.
  - start_i=0 -> FREE; ready_o=0 at that edge.
  - start_i=1 -> stay in END. Blocks a second start until the EX stage advances.
- stall_o = start_i & ~ready_o & ~annul_i.
- Latency from start (cycle 0):
  - Nonzero divisor: ready_o=1 in cycle 34 (1 load, 32 iterations, 1 fix-up). stall_o is high in cycles 0..33.
  - Divide by zero: ready_o=1 in cycle 2.
- Overflow case (signed 0x80000000 / 0xFFFFFFFF): quotient=0x80000000, remainder=0. No trap.
- Unsigned: no abs or negation. 0xFFFFFFFF is treated as 4294967295.
- annul_i together with start_i in FREE: no start.
- annul_i in END: -> FREE and ready_o=0.
- Reset mid-operation aborts immediately to the reset values.
- Operand inputs are sampled only on the FREE->ON/DIVZERO edge. Later changes to them are ignored.

Decomposition:
- Shared package:
  - state encoding constants (FREE=2'b00, DIVZERO=2'b01, ON=2'b10, END=2'b11)
  - DIV/DIVU alucontrol codes so EX decode and div_unit agree
  - WIDTH default
- One combinational sub-module, div_step: one restoring-division iteration. Inputs {rem, dvd} and divisor; outputs the next {rem, dvd} and the quotient bit.
- The FSM, counter and sign fix-up stay in div_unit.

Test Plan:
- DIVU 100 / 7, start held -> stall_o high cycles 0..33; cycle 34: ready_o=1, result_o={0x00000002, 0x0000000E}; start_i drop -> ready_o=0 next cycle.
- DIV -7 / 2 (0xFFFFFFF9, 0x00000002) -> result_o={0xFFFFFFFF, 0xFFFFFFFD} at cycle 34. Also DIV 7 / -2 -> {0x00000001, 0xFFFFFFFD}.
- DIV 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}. DIVU same operands -> {0x80000000, 0x00000000}.
- Divide by zero (opb=0) -> ready_o=1 at cycle 2, result_o=0, stall_o low from cycle 2.
- Start, then annul_i=1 at cycle 10 -> state FREE at cycle 11, ready_o never rises, stall_o low. A new start at cycle 12 (DIVU 9/3) -> {0, 3} at cycle 46.
- rst=0 at cycle 20 of a divide -> next cycle ready_o=0, result_o=0, FSM in FREE. A start after reset completes normally.
